// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: holds the PLL in reset, waits for lock with a timeout,
// qualifies lock stability, then releases downstream logic; re-sequences on lock loss.
`timescale 1ns/1ps

module pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 4096,
    parameter int unsigned TIMER_WIDTH   = 17,
    parameter int unsigned COUNT_WIDTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    input  logic                   clear_counts,
    output logic                   pll_reset,
    output logic                   downstream_reset,
    output logic                   ready,
    output logic [1:0]             state,
    output logic [COUNT_WIDTH-1:0] lock_loss_count,
    output logic [COUNT_WIDTH-1:0] retry_count
);

    typedef enum logic [1:0] {
        ST_PLL_RESET = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    localparam logic [TIMER_WIDTH-1:0] LP_RESET_LAST  = TIMER_WIDTH'(RESET_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] LP_LOCK_LAST   = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] LP_STABLE_LAST = TIMER_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [63:0]            LP_TIMER_SPAN  = 64'(1) << TIMER_WIDTH;

    // Configuration sanity: every duration must be >=2 and fit the timer.
    if (RESET_CYCLES < 2 || LOCK_TIMEOUT < 2 || STABLE_CYCLES < 2 ||
        64'(RESET_CYCLES) > LP_TIMER_SPAN || 64'(LOCK_TIMEOUT) > LP_TIMER_SPAN ||
        64'(STABLE_CYCLES) > LP_TIMER_SPAN) begin : g_cfg_error
        $error("pll_lock_sequencer: cycle parameter out of range for TIMER_WIDTH");
    end

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [TIMER_WIDTH-1:0]  r_timer;
    logic [TIMER_WIDTH-1:0]  w_timer_nxt;
    logic                    r_sync_1;
    logic                    r_sync_2;
    logic                    w_locked_s;
    logic                    w_retry_inc;
    logic                    w_loss_inc;
    logic                    w_pll_reset_nxt;
    logic                    w_ready_nxt;

    assign w_locked_s = r_sync_2;
    assign state      = r_state;

    // State, timer, synchronizer and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_1         <= 1'b0;
            r_sync_2         <= 1'b0;
            r_state          <= ST_PLL_RESET;
            r_timer          <= '0;
            pll_reset        <= 1'b1;
            ready            <= 1'b0;
            downstream_reset <= 1'b1;
        end else begin
            r_sync_1         <= pll_locked;
            r_sync_2         <= r_sync_1;
            r_state          <= w_state_nxt;
            r_timer          <= w_timer_nxt;
            pll_reset        <= w_pll_reset_nxt;
            ready            <= w_ready_nxt;
            downstream_reset <= !w_ready_nxt;
        end
    end

    // Next-state logic; lock takes priority over timeout in WAIT_LOCK.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_loss_inc  = 1'b0;
        case (r_state)
            ST_PLL_RESET: begin
                if (r_timer == LP_RESET_LAST) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_timer == LP_LOCK_LAST) begin
                    w_state_nxt = ST_PLL_RESET;
                    w_retry_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_PLL_RESET;
                    w_retry_inc = 1'b1;
                end else if (r_timer == LP_STABLE_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_PLL_RESET;
                    w_loss_inc  = 1'b1;
                end
            end
            default: w_state_nxt = ST_PLL_RESET;
        endcase
    end

    // Output and timer decode from next state so outputs move with the state register.
    always_comb begin
        w_pll_reset_nxt = (w_state_nxt == ST_PLL_RESET);
        w_ready_nxt     = (w_state_nxt == ST_RUN);
        w_timer_nxt     = r_timer;
        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
        end else if (r_state != ST_RUN) begin
            w_timer_nxt = r_timer + TIMER_WIDTH'(1);
        end
    end

    // Saturating event counters; clear has priority over increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_loss_count <= '0;
            retry_count     <= '0;
        end else if (clear_counts) begin
            lock_loss_count <= '0;
            retry_count     <= '0;
        end else begin
            if (w_loss_inc && (lock_loss_count != '1))
                lock_loss_count <= lock_loss_count + COUNT_WIDTH'(1);
            if (w_retry_inc && (retry_count != '1))
                retry_count <= retry_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: expected per-cycle states are queued as
// stimulus is planned and popped/checked one per clock after the rising edge.
`timescale 1ns/1ps

module tb_pll_lock_sequencer;

    logic       clock;
    logic       reset_n;
    logic       pll_locked;
    logic       clear_counts;
    logic       pll_reset;
    logic       downstream_reset;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_loss_count;
    logic [7:0] retry_count;

    int checks   = 0;
    int failures = 0;
    string phase = "init";
    logic [1:0] q_exp[$];

    pll_lock_sequencer #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (16),
        .STABLE_CYCLES(8),
        .TIMER_WIDTH  (17),
        .COUNT_WIDTH  (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .clear_counts    (clear_counts),
        .pll_reset       (pll_reset),
        .downstream_reset(downstream_reset),
        .ready           (ready),
        .state           (state),
        .lock_loss_count (lock_loss_count),
        .retry_count     (retry_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [1:0] s, input int n);
        repeat (n) q_exp.push_back(s);
    endtask

    // One clock per queued entry; outputs are fully determined by the expected state.
    task automatic drain();
        logic [1:0] e;
        while (q_exp.size() > 0) begin
            tick();
            e = q_exp.pop_front();
            chk("state",            32'(state),            32'(e));
            chk("pll_reset",        32'(pll_reset),        32'(e == 2'd0));
            chk("ready",            32'(ready),            32'(e == 2'd3));
            chk("downstream_reset", 32'(downstream_reset), 32'(e != 2'd3));
        end
    endtask

    task automatic chk_counts(input int loss, input int retry);
        chk("lock_loss_count", 32'(lock_loss_count), 32'(loss));
        chk("retry_count",     32'(retry_count),     32'(retry));
    endtask

    // Assert reset_n between edges, check values before the next edge, release at a falling edge.
    task automatic apply_reset();
        tick();
        #3 reset_n = 1'b0;
        #1;
        chk("rst_state",     32'(state),            32'd0);
        chk("rst_pll_reset", 32'(pll_reset),        32'd1);
        chk("rst_ready",     32'(ready),            32'd0);
        chk("rst_ds_reset",  32'(downstream_reset), 32'd1);
        chk_counts(0, 0);
        tick();
        tick();
        #4 reset_n = 1'b1;
    endtask

    // From reset release / PLL_RESET entry with lock present: 4 reset cycles, 1 wait, 8 stable, run.
    task automatic plan_lock_path(input int reset_samples);
        push_seq(2'd0, reset_samples);
        push_seq(2'd1, 1);
        push_seq(2'd2, 8);
        push_seq(2'd3, 1);
    endtask

    initial begin
        reset_n      = 1'b1;
        pll_locked   = 1'b1;
        clear_counts = 1'b0;

        phase = "t1_bringup";
        apply_reset();
        plan_lock_path(3);
        push_seq(2'd3, 2);
        drain();
        chk_counts(0, 0);

        phase = "t3_run_loss";
        pll_locked = 1'b0;
        push_seq(2'd3, 2);
        push_seq(2'd0, 1);
        drain();
        chk_counts(1, 0);
        pll_locked = 1'b1;
        push_seq(2'd0, 3);
        push_seq(2'd1, 1);
        push_seq(2'd2, 2);
        drain();

        phase = "t4_stable_drop";
        pll_locked = 1'b0;
        push_seq(2'd2, 2);
        drain();
        pll_locked = 1'b1;
        push_seq(2'd0, 1);
        drain();
        chk_counts(1, 1);
        plan_lock_path(3);
        drain();
        chk_counts(1, 1);

        phase = "t5_clear_vs_loss";
        push_seq(2'd3, 1);
        drain();
        pll_locked = 1'b0;
        push_seq(2'd3, 2);
        drain();
        clear_counts = 1'b1;
        push_seq(2'd0, 1);
        drain();
        clear_counts = 1'b0;
        pll_locked   = 1'b1;
        chk_counts(0, 0);
        plan_lock_path(3);
        drain();
        chk_counts(0, 0);

        phase = "t6_async_reset";
        pll_locked = 1'b0;
        push_seq(2'd3, 2);
        push_seq(2'd0, 4);
        push_seq(2'd1, 3);
        drain();
        chk_counts(1, 0);
        pll_locked = 1'b1;
        apply_reset();
        plan_lock_path(3);
        drain();
        chk_counts(0, 0);

        phase = "t2_retry_sat";
        pll_locked = 1'b0;
        apply_reset();
        push_seq(2'd0, 3);
        drain();
        for (int k = 1; k <= 258; k++) begin
            push_seq(2'd1, 16);
            push_seq(2'd0, 4);
            drain();
            chk("retry_sat", 32'(retry_count), 32'((k > 255) ? 255 : k));
        end
        chk("loss_after_retries", 32'(lock_loss_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Supervises the clock-synthesis PLL from the PLL's own input-clock domain, upstream of the PLL.
- Drives the PLL RESET pin and consumes its asynchronous LOCKED output.
- Holds the PLL in reset for a fixed time, waits for lock with a timeout, and requires lock to stay stable before releasing downstream logic.
- Re-sequences on any lock loss, with saturating lock-loss and retry counters for LEDs and debug.

Parameters:
- RESET_CYCLES, 1024: cycles pll_reset is held high per attempt (>=2).
- LOCK_TIMEOUT, 65536: cycles waited for lock before retrying (>=2).
- STABLE_CYCLES, 4096: consecutive locked cycles required before run (>=2).
- TIMER_WIDTH, 17: timer width; must hold max(parameters)-1.
- COUNT_WIDTH, 8: width of both event counters.

Ports:
- clock  input  1  PLL input clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- pll_locked  input  1  PLL LOCKED; asynchronous to clock.
- clear_counts  input  1  synchronous pulse; zeroes both counters.
- pll_reset  output  1  to PLL RESET; active high.
- downstream_reset  output  1  active-high reset for logic on PLL outputs.
- ready  output  1  high only in RUN.
- state  output  2  current state: 0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN.
- lock_loss_count  output  COUNT_WIDTH  lock drops seen while in RUN (saturating).
- retry_count  output  COUNT_WIDTH  lock timeouts plus drops during STABLE (saturating).

Behaviour:
- Reset values (reset_n low, async): state=PLL_RESET, timer=0, pll_reset=1, downstream_reset=1, ready=0, both counters 0, synchronizer flops 0.
- pll_locked passes through a 2-flop synchronizer (locked_s). The FSM sees a LOCKED edge 2 clock edges later.
- Every state entry clears the timer to 0. Otherwise the timer increments each cycle.
- PLL_RESET: transitions to WAIT_LOCK on the edge where timer==RESET_CYCLES-1. pll_reset is therefore high exactly RESET_CYCLES cycles per entry. locked_s is ignored here.
- WAIT_LOCK: if locked_s=1, go to STABLE. Else if timer==LOCK_TIMEOUT-1, go to PLL_RESET and increment retry_count. Lock wins if both occur in the same cycle.
- STABLE: if locked_s=0, go to PLL_RESET and increment retry_count. Else if timer==STABLE_CYCLES-1, go to RUN.
- RUN: if locked_s=0, go to PLL_RESET and increment lock_loss_count. Stay in RUN indefinitely otherwise; no timer action.
- Outputs are registered and decoded from next-state, so they change on the same edge as state:
  - pll_reset = (state==PLL_RESET)
  - ready = (state==RUN)
  - downstream_reset = !ready
  - No glitches on any output.
- Counters saturate at all-ones; there is no wrap.
- If clear_counts coincides with an increment, clear wins (result 0). clear_counts has no effect on the FSM.
- Deasserting reset_n mid-operation in any state immediately forces reset values. Sequencing restarts from PLL_RESET after release.
- A lock drop shorter than 1 clock can be missed by the synchronizer; this is acceptable.
- Timer comparisons use TIMER_WIDTH bits. Parameters exceeding 2^TIMER_WIDTH are a configuration error, flagged by a simulation-time check.

Test Plan:
(Run with RESET_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8.)
1. Release reset_n, pll_locked tied 1 -> pll_reset high exactly 4 cycles; state 0->1->2->3; ready rises 8 cycles after entering STABLE; downstream_reset falls on the same edge; both counters 0.
2. pll_locked held 0 -> pll_reset re-pulses for 4 cycles after every 16 cycles in WAIT_LOCK; retry_count increments each attempt and saturates at 255 with no wrap.
3. Reach RUN, then drop pll_locked for 3 cycles -> 2 cycles later state=PLL_RESET, ready=0, downstream_reset=1, lock_loss_count=1; after lock returns, RUN is re-entered via the full sequence.
4. Drop pll_locked for 2 cycles while in STABLE -> returns to PLL_RESET, retry_count+1, lock_loss_count unchanged, ready never asserted.
5. Assert clear_counts on the same cycle a lock loss is detected -> lock_loss_count=0 afterward; FSM still enters PLL_RESET.
6. Pulse reset_n low mid-WAIT_LOCK, asynchronous to clock -> outputs take reset values immediately, before the next edge; counters 0; sequence restarts with a full 4-cycle pll_reset.
